fetch_stage: RTL and testbench

//  Instruction-fetch stage: PC register, next-PC selection, instruction-memory request FSM and IF/ID pipeline register.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM state encoding and instruction-word constants.
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush (bubble) > hold > load.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               flush_i,
   input  logic               hold_i,
   input  logic               load_i,
   input  logic [ADDR_W-1:0]  pc_plus4_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [ADDR_W-1:0]  pc_plus4_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               valid_o
);

   logic [ADDR_W-1:0]  pc_plus4_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pc_plus4_q <= '0;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else if (flush_i) begin
         pc_plus4_q <= '0;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else if (!hold_i && load_i) begin
         pc_plus4_q <= pc_plus4_i;
         instr_q    <= instr_i;
         valid_q    <= 1'b1;
      end
   end

   assign pc_plus4_o = pc_plus4_q;
   assign instr_o    = instr_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC select, imem request FSM, IF/ID register.
// FETCH_PERF_CNT_EN adds stall-cycle and flush counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               stall_pc,
   input  logic               stall_if_id,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [ADDR_W-1:0]  if_id_pc_plus4,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cycles,
   output logic [31:0]        perf_flush_count
`endif
);

   fetch_state_e       state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] buf_q;
   logic               req_q;

   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic [ADDR_W-1:0]  pc_plus4;
   logic               deliver;
   logic [INSTR_W-1:0] deliver_word;
   logic               ifid_flush;

   assign redirect     = branch_taken | jump;
   assign redirect_pc  = branch_taken ? branch_target : jump_target;
   assign pc_plus4     = pc_q + ADDR_W'(4);
   assign deliver      = ~redirect & ~stall_if_id &
                         (((state_q == S_WAIT) & imem_valid) | (state_q == S_HOLD));
   assign deliver_word = (state_q == S_HOLD) ? buf_q : imem_rdata;
   // Any cycle without a delivered word becomes a bubble unless IF/ID is frozen.
   assign ifid_flush   = redirect | (~deliver & ~stall_if_id);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         buf_q   <= NOP_INSTR;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (redirect) pc_q <= redirect_pc;
               state_q <= S_WAIT;
               req_q   <= 1'b1;
            end
            S_WAIT: begin
               if (redirect) begin
                  pc_q <= redirect_pc;
                  // A response in the same cycle retires the wrong-path request.
                  state_q <= imem_valid ? S_WAIT : S_DROP;
                  req_q   <= imem_valid;
               end else if (imem_valid) begin
                  if (stall_if_id) begin
                     buf_q   <= imem_rdata;
                     state_q <= S_HOLD;
                     req_q   <= 1'b0;
                  end else if (!stall_pc) begin
                     pc_q <= pc_plus4;
                  end
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  pc_q    <= redirect_pc;
                  state_q <= S_WAIT;
                  req_q   <= 1'b1;
               end else if (!stall_if_id) begin
                  if (!stall_pc) pc_q <= pc_plus4;
                  state_q <= S_WAIT;
                  req_q   <= 1'b1;
               end
            end
            S_DROP: begin
               if (redirect) pc_q <= redirect_pc;
               if (imem_valid) begin
                  state_q <= S_WAIT;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
      .clk        (clk),
      .arst_n     (arst_n),
      .flush_i    (ifid_flush),
      .hold_i     (stall_if_id),
      .load_i     (deliver),
      .pc_plus4_i (pc_plus4),
      .instr_i    (deliver_word),
      .pc_plus4_o (if_id_pc_plus4),
      .instr_o    (if_id_instr),
      .valid_o    (if_id_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stall_if_id) perf_stall_q <= perf_stall_q + 32'd1;
         if (redirect)    perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected {pc+4, instr} entries are queued
// ahead of time and popped each time a new word lands in IF/ID.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        stall_pc, stall_if_id, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic        imem_req, imem_valid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] if_id_pc_plus4, if_id_instr;
   logic        if_id_valid;

   logic        imem_req2, if_id_valid2;
   logic [31:0] imem_addr2, if_id_pc_plus42, if_id_instr2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_flush_count, perf_stall_cycles2, perf_flush_count2;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .arst_n(arst_n), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
   );

   // Second instance checks PC wrap; its memory answers in the request cycle.
   fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .arst_n(arst_n), .stall_pc(1'b0), .stall_if_id(1'b0),
      .branch_taken(1'b0), .branch_target(32'h0), .jump(1'b0), .jump_target(32'h0),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(32'h5), .imem_valid(imem_req2),
      .if_id_pc_plus4(if_id_pc_plus42), .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2)
`ifdef FETCH_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles2), .perf_flush_count(perf_flush_count2)
`endif
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          n_pop = 0;
   logic [63:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic push_pc(input logic [31:0] pc);
      exp_q.push_back({pc + 32'd4, pc >> 2});
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // Memory model: word at address 4*i is i; response lat cycles after the
   // request is first seen, and it is delivered even if req drops meanwhile.
   int          lat = 1;
   logic        pend = 1'b0;
   logic [31:0] paddr = '0;
   int          cnt = 0;
   initial begin
      imem_valid = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge clk);
         #3;
         imem_valid = 1'b0;
         if (!pend && imem_req) begin
            pend  = 1'b1;
            paddr = imem_addr;
            cnt   = 0;
         end
         if (pend) begin
            cnt++;
            if (cnt >= lat) begin
               imem_valid = 1'b1;
               imem_rdata = paddr >> 2;
               pend       = 1'b0;
            end
         end
      end
   end

   // IF/ID only takes a new word on an edge where stall_if_id was low.
   logic prev_stall = 1'b1;
   initial forever begin
      @(posedge clk);
      prev_stall = stall_if_id;
   end

   initial forever begin
      @(negedge clk);
      if (arst_n && if_id_valid && !prev_stall) begin
         if (exp_q.size() == 0) begin
            chk("extra_word", 32'(if_id_valid), 32'd0);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            n_pop++;
            chk("sb_instr", if_id_instr, e[31:0]);
            chk("sb_pc4", if_id_pc_plus4, e[63:32]);
         end
      end
   end

   task automatic wait_pop(input int n);
      for (int i = 0; i < 60; i++) begin
         if (n_pop >= n) break;
         step();
      end
      if (n_pop < n) chk("timeout_pop", n_pop, n);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      if (exp_q.size() != 0) chk("timeout_empty", exp_q.size(), 0);
   endtask

   task automatic set_stall(input logic s);
      stall_pc    = s;
      stall_if_id = s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arst_n = 1'b0;
      set_stall(1'b0);
      branch_taken = 1'b0; branch_target = '0;
      jump = 1'b0; jump_target = '0;
      step(); step();
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(if_id_valid), 0);
      chk("rst_instr", if_id_instr, 0);
      chk("rst_pc4", if_id_pc_plus4, 0);

      // Streaming with 1-cycle memory, then a 2-cycle full freeze.
      for (int i = 0; i < 6; i++) push_pc(32'(4 * i));
      arst_n = 1'b1;
      step();
      chk("first_req", 32'(imem_req), 1);
      chk("first_addr", imem_addr, 32'h0);
      chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
      step();
      chk("wrap_second_addr", imem_addr2, 32'h0);
      chk("wrap_pc4", if_id_pc_plus42, 32'h0);
      chk("wrap_valid", 32'(if_id_valid2), 1);
      wait_pop(3);
      set_stall(1'b1);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("frz_instr", if_id_instr, 32'd2);
         chk("frz_pc4", if_id_pc_plus4, 32'd12);
         chk("frz_valid", 32'(if_id_valid), 1);
         chk("frz_req", 32'(imem_req), 0);
      end
      set_stall(1'b0);
      wait_empty();
      set_stall(1'b1);
      repeat (3) step();

      // Taken branch (with a simultaneous jump) while a 3-cycle fetch is in flight.
      push_pc(32'd24);
      push_pc(32'h100);
      lat = 3;
      set_stall(1'b0);
      step(); step();
      branch_taken = 1'b1; branch_target = 32'h100;
      jump = 1'b1; jump_target = 32'h300;
      step();
      branch_taken = 1'b0; jump = 1'b0;
      chk("drop_req", 32'(imem_req), 0);
      chk("drop_valid", 32'(if_id_valid), 0);
      chk("drop_instr", if_id_instr, 32'h0);
      step();
      chk("br_req", 32'(imem_req), 1);
      chk("br_addr", imem_addr, 32'h100);
      wait_empty();
      set_stall(1'b1);
      repeat (4) step();
      chk("park_req", 32'(imem_req), 0);

      // Jump landing in the same cycle as a response.
      push_pc(32'h104); push_pc(32'h108);
      push_pc(32'h200); push_pc(32'h204);
      lat = 1;
      set_stall(1'b0);
      step(); step();
      jump = 1'b1; jump_target = 32'h200;
      step();
      jump = 1'b0;
      chk("jmp_valid", 32'(if_id_valid), 0);
      chk("jmp_instr", if_id_instr, 32'h0);
      chk("jmp_req", 32'(imem_req), 1);
      chk("jmp_addr", imem_addr, 32'h200);
      wait_empty();
      set_stall(1'b1);
      repeat (3) step();

      // Reset while a 3-cycle fetch is outstanding; the response lands in reset.
      push_pc(32'h208);
      lat = 3;
      set_stall(1'b0);
      step();
      arst_n = 1'b0;
      step();
      chk("mrst_req", 32'(imem_req), 0);
      chk("mrst_valid", 32'(if_id_valid), 0);
      step();
      push_pc(32'h0);
      arst_n = 1'b1;
      step();
      chk("mrst_req_after", 32'(imem_req), 1);
      chk("mrst_addr_after", imem_addr, 32'h0);
      wait_empty();
      set_stall(1'b1);
      repeat (4) step();
      chk("sb_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
